lut_layer_engine: RTL and testbench

Parametrised, pipelined successor to the single-neuron truth-table LUT: one layer of NEURONS independent LUT neurons.
- Each neuron maps an ADDR_W-bit input slice to an OUT_W-bit output.
- Truth tables are held in runtime-programmable registers rather than fixed ROM contents.
- Per-layer results leave through a registered valid/ready stage.
- Sits between upstream connectivity wiring (which packs each neuron's fan-in bits into its slice) and the next layer or the classifier output.

---
 rtl/lut_layer_engine_if.sv | 36 +++
 rtl/lut_layer_engine.sv | 95 +++++++++
 tb/tb_lut_layer_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_engine_if.sv
// Bundles the streaming and configuration signals of one LUT layer.
// The slave modport is the engine side and the master modport is the driver side.
interface lut_layer_engine_if #(
   parameter int unsigned NEURONS = 4,
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned OUT_W   = 2
);
   localparam int unsigned NID_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

   logic                      in_valid;
   logic                      in_ready;
   logic [NEURONS*ADDR_W-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [NEURONS*OUT_W-1:0]  out_data;
   logic                      cfg_we;
   logic [NID_W-1:0]          cfg_neuron;
   logic [ADDR_W-1:0]         cfg_addr;
   logic [OUT_W-1:0]          cfg_data;
   logic                      cfg_start;
   logic                      cfg_done;
   logic                      cfg_mode;
   logic                      cfg_err;

   modport master (
      output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
             cfg_start, cfg_done,
      input  in_ready, out_valid, out_data, cfg_mode, cfg_err
   );

   modport slave (
      input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
             cfg_start, cfg_done,
      output in_ready, out_valid, out_data, cfg_mode, cfg_err
   );
endinterface

// File: rtl/lut_layer_engine.sv
// One layer of independent, runtime-programmable truth-table neurons.
// Every neuron's lookup is captured in one shared registered valid/ready output stage.
module lut_layer_engine #(
   parameter int unsigned NEURONS = 4,
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned OUT_W   = 2
) (
   input logic              clk,
   input logic              rst,
   lut_layer_engine_if.slave bus_io
);
   localparam int unsigned NID_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [NID_W:0] NeuronsW = (NID_W + 1)'(NEURONS);

   typedef enum logic [1:0] {StCfg, StRun, StDrain} state_e;

   state_e                   state_q, state_d;
   logic [OUT_W-1:0]         tbl_q [NEURONS][DEPTH];
   logic                     out_valid_q, out_valid_d;
   logic [NEURONS*OUT_W-1:0] out_data_q, out_data_d;
   logic                     cfg_err_q, cfg_err_d;
   logic [NEURONS*OUT_W-1:0] lookup;
   logic                     in_ready;
   logic                     accept;
   logic                     nid_ok;
   logic                     tbl_we;

   assign nid_ok   = {1'b0, bus_io.cfg_neuron} < NeuronsW;
   assign tbl_we   = (state_q == StCfg) && bus_io.cfg_we && nid_ok;
   assign in_ready = (state_q == StRun) && (!out_valid_q || bus_io.out_ready);
   assign accept   = bus_io.in_valid && in_ready;

   always_comb begin
      lookup = '0;
      for (int unsigned n = 0; n < NEURONS; n++) begin
         lookup[n*OUT_W +: OUT_W] = tbl_q[n][bus_io.in_data[n*ADDR_W +: ADDR_W]];
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      // Any config write outside CFG, or to a nonexistent neuron, is rejected.
      cfg_err_d   = bus_io.cfg_we && ((state_q != StCfg) || !nid_ok);

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = lookup;
      end else if (out_valid_q && bus_io.out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StCfg:   if (bus_io.cfg_done) state_d = StRun;
         StRun:   if (bus_io.cfg_start) state_d = StDrain;
         StDrain: if (!out_valid_q || bus_io.out_ready) state_d = StCfg;
         default: state_d = StCfg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StCfg;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Tables sit in flops so the lookup can feed the output register combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < NEURONS; n++) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
               tbl_q[n][a] <= '0;
            end
         end
      end else if (tbl_we) begin
         tbl_q[bus_io.cfg_neuron][bus_io.cfg_addr] <= bus_io.cfg_data;
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
   assign bus_io.cfg_mode  = (state_q == StCfg);
   assign bus_io.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_lut_layer_engine.sv
// Scoreboard bench for lut_layer_engine: stimulus pushes expected words, a monitor pops them.
// Three neurons are used so that a 2-bit neuron select can address a nonexistent neuron.
module tb_lut_layer_engine;
   localparam int unsigned N  = 3;
   localparam int unsigned AW = 6;
   localparam int unsigned OW = 2;
   localparam int unsigned IWID = N * AW;
   localparam int unsigned OWID = N * OW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;
   int   cyc_cnt = 0;
   logic [OWID-1:0] exp_q [$];

   lut_layer_engine_if #(.NEURONS(N), .ADDR_W(AW), .OUT_W(OW)) bus ();

   lut_layer_engine #(.NEURONS(N), .ADDR_W(AW), .OUT_W(OW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every output handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
         end else begin
            chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   function automatic logic [IWID-1:0] mk(input logic [5:0] s0, input logic [5:0] s1,
                                          input logic [5:0] s2);
      return {s2, s1, s0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IWID-1:0] d, input logic [OWID-1:0] e);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
      else exp_q.push_back(e);
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d,
                            input logic done);
      bus.cfg_we     = 1'b1;
      bus.cfg_neuron = n;
      bus.cfg_addr   = a;
      bus.cfg_data   = d;
      bus.cfg_done   = done;
      cyc();
      bus.cfg_we   = 1'b0;
      bus.cfg_done = 1'b0;
   endtask

   task automatic check_err_pulse(input string name);
      chk({name, "_err_hi"}, 32'(bus.cfg_err), 32'd1);
      cyc();
      chk({name, "_err_lo"}, 32'(bus.cfg_err), 32'd0);
   endtask

   task automatic pulse_done();
      bus.cfg_done = 1'b1;
      cyc();
      bus.cfg_done = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_cfg_mode"}, 32'(bus.cfg_mode), 32'd1);
      chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_out_data"}, 32'(bus.out_data), 32'd0);
      chk({name, "_cfg_err"}, 32'(bus.cfg_err), 32'd0);
   endtask

   initial begin
      int t0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus.cfg_we     = 1'b0;
      bus.cfg_neuron = '0;
      bus.cfg_addr   = '0;
      bus.cfg_data   = '0;
      bus.cfg_start  = 1'b0;
      bus.cfg_done   = 1'b0;

      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      cyc();
      check_reset_outputs("reset");

      // Empty tables look up as zero.
      pulse_done();
      chk("run_cfg_mode", 32'(bus.cfg_mode), 32'd0);
      chk("run_in_ready", 32'(bus.in_ready), 32'd1);
      send(mk(6'h00, 6'h10, 6'h3F), 6'b00_00_00);
      cyc();

      // Reset between edges while idle in RUN.
      #2 rst = 1'b1;
      #1 check_reset_outputs("idle_reset");
      cyc();
      rst = 1'b0;
      cyc();

      cfg_write(2'd3, 6'h00, 2'b11, 1'b0);
      check_err_pulse("cfg_bad_neuron");
      cfg_write(2'd0, 6'h00, 2'b10, 1'b0);
      chk("legal_write_no_err", 32'(bus.cfg_err), 32'd0);
      cfg_write(2'd0, 6'h20, 2'b00, 1'b0);
      cfg_write(2'd1, 6'h10, 2'b11, 1'b0);
      cfg_write(2'd2, 6'h3F, 2'b01, 1'b1);
      chk("write_done_cfg_mode", 32'(bus.cfg_mode), 32'd0);

      // Back-to-back stream at one word per clock.
      t0 = cyc_cnt;
      send(mk(6'h00, 6'h10, 6'h3F), 6'b01_11_10);
      send(mk(6'h20, 6'h00, 6'h00), 6'b00_00_00);
      send(mk(6'h00, 6'h00, 6'h3F), 6'b01_00_10);
      chk("stream_cycles", 32'(cyc_cnt - t0), 32'd3);
      cyc();

      // Backpressure: held word stays put, then transfers as the next one is captured.
      bus.out_ready = 1'b0;
      send(mk(6'h00, 6'h10, 6'h00), 6'b00_11_10);
      bus.in_valid = 1'b1;
      bus.in_data  = mk(6'h20, 6'h10, 6'h3F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_out_data", 32'(bus.out_data), 32'(6'b00_11_10));
      end
      cyc();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      exp_q.push_back(6'b01_11_00);
      cyc();
      bus.in_valid = 1'b0;
      cyc();

      // Reconfigure while a word is stalled.
      bus.out_ready = 1'b0;
      send(mk(6'h20, 6'h00, 6'h3F), 6'b01_00_00);
      bus.cfg_start = 1'b1;
      cyc();
      bus.cfg_start = 1'b0;
      chk("drain_cfg_mode", 32'(bus.cfg_mode), 32'd0);
      chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
      chk("drain_out_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_out_data", 32'(bus.out_data), 32'(6'b01_00_00));
      cfg_write(2'd0, 6'h00, 2'b11, 1'b0);
      check_err_pulse("drain_write");
      bus.in_valid = 1'b1;
      bus.in_data  = mk(6'h00, 6'h00, 6'h00);
      #1 chk("drain_in_ready_valid", 32'(bus.in_ready), 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      chk("drain_to_cfg", 32'(bus.cfg_mode), 32'd1);
      chk("drain_out_cleared", 32'(bus.out_valid), 32'd0);
      cfg_write(2'd0, 6'h00, 2'b01, 1'b1);
      send(mk(6'h00, 6'h10, 6'h00), 6'b00_11_01);
      cyc();

      // Writes in RUN are rejected and leave the table alone.
      cfg_write(2'd0, 6'h00, 2'b11, 1'b0);
      check_err_pulse("run_write");
      send(mk(6'h00, 6'h00, 6'h00), 6'b00_00_01);
      cyc();

      // Async reset mid-stream with a word pending.
      bus.out_ready = 1'b0;
      send(mk(6'h00, 6'h10, 6'h3F), 6'b01_11_01);
      chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      exp_q.delete();
      cyc();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      pulse_done();
      send(mk(6'h00, 6'h10, 6'h3F), 6'b00_00_00);
      repeat (3) cyc();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
